// File: rtl/myproject_dense_acc.sv
// Dense-layer accumulator: sums N_IN signed products plus a bias per frame,
// then shifts and saturates the sum into a registered, handshaked result.
module myproject_dense_acc #(
  parameter int PROD_WIDTH = 18,
  parameter int N_IN       = 4,
  parameter int SHIFT      = 0,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic signed [PROD_WIDTH-1:0] prod_data,
  input  logic                         prod_valid,
  output logic                         prod_ready,
  input  logic signed [PROD_WIDTH-1:0] bias,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int ACC_WIDTH = PROD_WIDTH + $clog2(N_IN) + 1;
  localparam int CNT_WIDTH = $clog2(N_IN + 1);
  // One spare bit above the wider of sum/output keeps the saturation compare exact.
  localparam int EXT_WIDTH = ((ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(N_IN - 1);
  localparam logic signed [EXT_WIDTH-1:0] MAX_V =
    {{(EXT_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_WIDTH-1:0] MIN_V =
    {{(EXT_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                        state, state_next;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic [CNT_WIDTH-1:0]          cnt;
  logic signed [ACC_WIDTH-1:0]   prod_ext, bias_ext, sum;
  logic signed [EXT_WIDTH-1:0]   sum_ext, shifted;
  logic signed [OUT_WIDTH-1:0]   sat_data;
  logic                          sat_flag;
  logic                          accept, last_beat;

  assign prod_ready = (state != OUT);
  assign out_valid  = (state == OUT);
  assign busy       = (state != IDLE);
  assign accept     = prod_valid && prod_ready;

  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
  assign bias_ext = {{(ACC_WIDTH-PROD_WIDTH){bias[PROD_WIDTH-1]}}, bias};
  assign sum      = (state == IDLE) ? (bias_ext + prod_ext) : (acc + prod_ext);
  assign last_beat = (state == IDLE) ? (N_IN == 1) : (cnt == LAST_CNT);

  assign sum_ext = {{(EXT_WIDTH-ACC_WIDTH){sum[ACC_WIDTH-1]}}, sum};
  assign shifted = sum_ext >>> SHIFT;

  always_comb begin
    sat_data = shifted[OUT_WIDTH-1:0];
    sat_flag = 1'b0;
    if (shifted > MAX_V) begin
      sat_data = MAX_V[OUT_WIDTH-1:0];
      sat_flag = 1'b1;
    end else if (shifted < MIN_V) begin
      sat_data = MIN_V[OUT_WIDTH-1:0];
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = last_beat ? OUT : ACC;
      ACC:     if (accept && last_beat) state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The result register is loaded from the same-cycle sum so the output appears one cycle after the last beat.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      if (last_beat) begin
        cnt      <= '0;
        out_data <= sat_data;
        out_sat  <= sat_flag;
      end else if (state == IDLE) begin
        cnt <= CNT_WIDTH'(1);
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_myproject_dense_acc.sv
// Scoreboard bench for myproject_dense_acc: two instances (SHIFT=0 and SHIFT=2)
// share stimulus; expectations come from a plain-arithmetic frame model.
module tb_myproject_dense_acc;

  localparam int PW = 18;
  localparam int OW = 16;

  typedef struct {
    longint data;
    bit     sat;
  } exp_t;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst_n = 1'b0;
  logic signed [PW-1:0] prod_data = '0;
  logic                 prod_valid = 1'b0;
  logic signed [PW-1:0] bias = '0;
  logic                 out_ready;
  logic                 force_val = 1'b1;
  logic                 rand_mode = 1'b0;
  logic                 rand_bit = 1'b0;

  logic signed [OW-1:0] out_data0, out_data1;
  logic                 out_sat0, out_sat1, out_valid0, out_valid1;
  logic                 prod_ready0, prod_ready1, busy0, busy1;

  int checks = 0;
  int passes = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  logic signed [PW-1:0] frame[4];
  logic signed [PW-1:0] fbias;

  bit                   hold0 = 0, hold1 = 0;
  logic signed [OW-1:0] held_d0, held_d1;
  logic                 held_s0, held_s1;

  assign out_ready = rand_mode ? rand_bit : force_val;

  myproject_dense_acc #(.PROD_WIDTH(PW), .N_IN(4), .SHIFT(0), .OUT_WIDTH(OW)) u_dut0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .prod_data(prod_data), .prod_valid(prod_valid),
    .prod_ready(prod_ready0), .bias(bias), .out_data(out_data0), .out_sat(out_sat0),
    .out_valid(out_valid0), .out_ready(out_ready), .busy(busy0));

  myproject_dense_acc #(.PROD_WIDTH(PW), .N_IN(4), .SHIFT(2), .OUT_WIDTH(OW)) u_dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .prod_data(prod_data), .prod_valid(prod_valid),
    .prod_ready(prod_ready1), .bias(bias), .out_data(out_data1), .out_sat(out_sat1),
    .out_valid(out_valid1), .out_ready(out_ready), .busy(busy1));

  initial forever #5 ap_clk = ~ap_clk;

  initial forever begin
    @(posedge ap_clk);
    #2 rand_bit = 1'($urandom_range(0, 1));
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic report_fail(input string name);
    checks++;
    $display("[TB] FAIL %s: got event, expected none", name);
  endtask

  // Floor division by 2^k done with ordinary integer division.
  function automatic longint floor_shift(input longint s, input int k);
    longint d = longint'(1) << k;
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  function automatic exp_t model(input longint total, input int k);
    exp_t   r;
    longint v    = floor_shift(total, k);
    longint maxv = (longint'(1) << (OW - 1)) - 1;
    longint minv = -(longint'(1) << (OW - 1));
    if (v > maxv)      begin r.data = maxv; r.sat = 1; end
    else if (v < minv) begin r.data = minv; r.sat = 1; end
    else               begin r.data = v;    r.sat = 0; end
    return r;
  endfunction

  task automatic send_beat(input logic signed [PW-1:0] d, input logic signed [PW-1:0] b,
                           output bit ok);
    int waited = 0;
    ok = 1;
    prod_data  = d;
    bias       = b;
    prod_valid = 1'b1;
    @(negedge ap_clk);
    while (!prod_ready0) begin
      waited++;
      if (waited > 1000) begin
        report_fail("prod_ready_timeout");
        prod_valid = 1'b0;
        ok = 0;
        return;
      end
      @(negedge ap_clk);
    end
    @(posedge ap_clk);
    #1;
    prod_valid = 1'b0;
    prod_data  = PW'($urandom);
    bias       = PW'($urandom);
  endtask

  task automatic apply_stimulus(input int gap, input bit push);
    longint total = longint'(fbias);
    bit     ok;
    for (int i = 0; i < 4; i++) total += longint'(frame[i]);
    if (push) begin
      q0.push_back(model(total, 0));
      q1.push_back(model(total, 2));
    end
    for (int i = 0; i < 4; i++) begin
      send_beat(frame[i], (i == 0) ? fbias : PW'($urandom), ok);
      if (!ok) return;
      if (i < 3) begin
        check_output("busy_mid_frame", busy0, 1);
        check_output("no_early_valid", out_valid0, 0);
        repeat (gap) begin
          @(posedge ap_clk);
          #1;
        end
      end else begin
        check_output("latency_valid0", out_valid0, 1);
        check_output("latency_valid1", out_valid1, 1);
      end
    end
  endtask

  task automatic set_frame(input int b, input int p0, input int p1, input int p2, input int p3);
    fbias    = PW'(b);
    frame[0] = PW'(p0);
    frame[1] = PW'(p1);
    frame[2] = PW'(p2);
    frame[3] = PW'(p3);
  endtask

  // Monitor: pops one expectation per output handshake and checks hold under backpressure.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      hold0 = 0;
      hold1 = 0;
    end else begin
      if (hold0) begin
        check_output("hold_data0", out_data0, held_d0);
        check_output("hold_sat0", out_sat0, held_s0);
      end
      if (hold1) begin
        check_output("hold_data1", out_data1, held_d1);
        check_output("hold_sat1", out_sat1, held_s1);
      end
      if (out_valid0) check_output("ready_low_in_out", prod_ready0, 0);
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) report_fail("unexpected_out0");
        else begin
          e0 = q0.pop_front();
          check_output("out_data0", out_data0, e0.data);
          check_output("out_sat0", out_sat0, e0.sat);
        end
      end
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) report_fail("unexpected_out1");
        else begin
          e1 = q1.pop_front();
          check_output("out_data1", out_data1, e1.data);
          check_output("out_sat1", out_sat1, e1.sat);
        end
      end
      hold0   = out_valid0 && !out_ready;
      hold1   = out_valid1 && !out_ready;
      held_d0 = out_data0;
      held_s0 = out_sat0;
      held_d1 = out_data1;
      held_s1 = out_sat1;
    end
  end

  initial begin
    #12;
    check_output("reset_valid", out_valid0, 0);
    check_output("reset_busy", busy0, 0);
    check_output("reset_data", out_data0, 0);
    @(posedge ap_clk);
    #3 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    check_output("ready_after_reset", prod_ready0, 1);

    // Back-to-back basic frame.
    set_frame(10, 100, -50, 25, 7);
    apply_stimulus(0, 1);
    @(posedge ap_clk);
    #1;

    // Gaps between beats and 5 cycles of backpressure.
    force_val = 1'b0;
    set_frame(10, 100, -50, 25, 7);
    apply_stimulus(2, 1);
    repeat (5) begin
      @(posedge ap_clk);
      #1;
    end
    check_output("held_valid", out_valid0, 1);
    check_output("held_value", out_data0, 92);
    force_val = 1'b1;
    @(posedge ap_clk);
    #1;
    check_output("idle_after_handshake", busy0, 0);
    check_output("valid_drop", out_valid0, 0);

    // Saturation and floor-shift cases.
    set_frame(0, 131071, 131071, 131071, 131071);
    apply_stimulus(0, 1);
    set_frame(0, -131072, -131072, -131072, -131072);
    apply_stimulus(1, 1);
    set_frame(0, -5, 0, 0, 0);
    apply_stimulus(0, 1);
    set_frame(0, 7, 0, 0, 0);
    apply_stimulus(0, 1);
    @(posedge ap_clk);
    #1;

    // Reset in the middle of a frame.
    begin
      bit ok;
      send_beat(PW'(1000), PW'(0), ok);
      send_beat(PW'(1000), PW'(77), ok);
    end
    check_output("busy_before_reset", busy0, 1);
    #2 ap_rst_n = 1'b0;
    #1;
    check_output("async_reset_busy", busy0, 0);
    check_output("async_reset_valid", out_valid0, 0);
    @(posedge ap_clk);
    #3 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    check_output("ready_after_mid_reset", prod_ready0, 1);
    set_frame(0, 1, 1, 1, 1);
    apply_stimulus(0, 1);
    @(posedge ap_clk);
    #1;

    // Reset while a result is pending; that result is discarded.
    force_val = 1'b0;
    set_frame(3, 500, 500, 500, 500);
    apply_stimulus(0, 0);
    #2 ap_rst_n = 1'b0;
    #1;
    check_output("async_reset_out_valid", out_valid0, 0);
    check_output("async_reset_out_data", out_data0, 0);
    @(posedge ap_clk);
    #3 ap_rst_n = 1'b1;
    force_val = 1'b1;
    @(posedge ap_clk);
    #1;
    check_output("ready_after_out_reset", prod_ready0, 1);

    // Randomized frames with random gaps and random downstream readiness.
    rand_mode = 1'b1;
    for (int f = 0; f < 30; f++) begin
      if (f % 2 == 1) begin
        fbias = PW'(int'($urandom_range(0, 2000)) - 1000);
        for (int i = 0; i < 4; i++) frame[i] = PW'(int'($urandom_range(0, 20000)) - 10000);
      end else begin
        fbias = PW'($urandom);
        for (int i = 0; i < 4; i++) frame[i] = PW'($urandom);
      end
      apply_stimulus(int'($urandom_range(0, 2)), 1);
    end

    rand_mode = 1'b0;
    force_val = 1'b1;
    repeat (5) begin
      @(posedge ap_clk);
      #1;
    end
    check_output("queue0_drained", q0.size(), 0);
    check_output("queue1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/myproject_dense_acc.md
MYPROJECT_DENSE_ACC -- requirements
Module: myproject_dense_acc

Interface
REQ-001 SHALL have parameter PROD_WIDTH, default 18: width of the signed product input.
REQ-002 SHALL have parameter N_IN, default 4, range 1..1024: number of products summed per output.
REQ-003 SHALL have parameter SHIFT, default 0: arithmetic right shift applied to the sum before saturation.
REQ-004 SHALL have parameter OUT_WIDTH, default 16: width of the signed output.
REQ-005 SHALL derive localparam ACC_WIDTH = PROD_WIDTH + clog2(N_IN) + 1.
REQ-006 SHALL have ports:
 ap_clk  in  1  clock; all state changes on the rising edge.
 ap_rst_n  in  1  asynchronous, active-low reset.
 prod_data  in  PROD_WIDTH  signed product from the upstream multiplier.
 prod_valid  in  1  prod_data valid.
 prod_ready  out  1  block accepts prod_data.
 bias  in  PROD_WIDTH  signed bias; sampled with the first product of a frame.
 out_data  out  OUT_WIDTH  signed, saturated result.
 out_sat  out  1  out_data was clipped.
 out_valid  out  1  result valid.
 out_ready  in  1  downstream accepts the result.
 busy  out  1  a frame is in progress (state != IDLE).

Function
REQ-007 SHALL implement three states: IDLE, ACC, OUT.
REQ-008 SHALL define a product beat as accepted in a cycle where prod_valid=1 and prod_ready=1.
REQ-009 SHALL drive prod_ready=1 in IDLE and ACC, and 0 in OUT.
REQ-010 On an accepted beat in IDLE, SHALL load acc = sext(bias) + sext(prod_data), set cnt=1, and go to ACC.
REQ-011 On an accepted beat in ACC, SHALL set acc = acc + sext(prod_data) and cnt = cnt + 1.
REQ-012 When the accepted beat is the N_IN-th of the frame, SHALL register out_data and out_sat from the updated sum, go to OUT, and reset cnt to 0.
REQ-013 For N_IN=1, the first beat accepted in IDLE SHALL go directly to OUT.
REQ-014 SHALL tolerate prod_valid gaps of any length: state, acc and cnt hold and nothing is accepted.
REQ-015 SHALL size the sum at ACC_WIDTH; no intermediate overflow is permitted for any input values.
REQ-016 Result SHALL be sum >>> SHIFT, an arithmetic shift that rounds toward minus infinity.
REQ-017 SHALL saturate the shifted value to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and set out_sat=1 when clipped, else 0.
REQ-018 SHALL assert out_valid exactly in OUT, i.e. in the cycle after the final beat is accepted (latency 1 cycle).
REQ-019 SHALL hold out_data and out_sat stable while out_valid=1 and out_ready=0.
REQ-020 SHALL return to IDLE in the cycle after out_valid=1 and out_ready=1; out_valid then deasserts.
REQ-021 Minimum frame period SHALL be N_IN+1 cycles; no overlap between frames.
REQ-022 bias SHALL be ignored except in the cycle the first beat of a frame is accepted.

Reset
REQ-023 ap_rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, acc=0, cnt=0, out_data=0, out_sat=0, out_valid=0, busy=0.
REQ-024 A reset asserted mid-frame or in OUT SHALL discard the partial sum and pending result.
REQ-025 After ap_rst_n rises, prod_ready SHALL be 1 and the next accepted beat SHALL start a new frame.

Verification
REQ-026 Reset: assert ap_rst_n=0 between clock edges -> out_valid=0 and busy=0 without waiting for a clock edge; after release, prod_ready=1.
REQ-027 Basic (N_IN=4, SHIFT=0): bias=10; products 100, -50, 25, 7 on back-to-back cycles -> out_data=92, out_sat=0, out_valid high the cycle after the 4th beat.
REQ-028 Backpressure/gaps: same frame with 2 idle cycles between beats and out_ready=0 for 5 cycles -> out_data=92 held, prod_ready=0 throughout OUT, IDLE one cycle after out_ready=1.
REQ-029 Saturation: bias=0, 4 x 131071 -> out_data=32767, out_sat=1; bias=0, 4 x -131072 -> out_data=-32768, out_sat=1.
REQ-030 Shift (SHIFT=2): bias=0; products -5, 0, 0, 0 -> out_data=-2 (floor); products 7, 0, 0, 0 -> out_data=1.
REQ-031 Reset mid-frame: 2 beats of 1000, then reset pulse, then frame bias=0 with 1, 1, 1, 1 -> out_data=4.
